mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arb_pkg.sv | 14 +
 rtl/mult_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the two-requester multiplier arbiter.
package mult_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    WAIT  = 3'd2,
    DROP  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 70000;

endpackage

// File: rtl/mult_arbiter.sv
// Round-robin arbiter granting two requesters access to one shared
// sign-magnitude multiplier, with a watchdog abort on a stuck multiplier.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] result,
  output logic        err,
  output logic        busy,
  output logic        mul_start,
  output logic [15:0] mul_in1,
  output logic [15:0] mul_in2,
  input  logic [15:0] mul_out,
  input  logic        mul_finish
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              abort_q, abort_d;
  logic [15:0]       in1_q, in1_d;
  logic [15:0]       in2_q, in2_d;
  logic [15:0]       result_q, result_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;

  logic              sel_win;
  logic [15:0]       sel_a, sel_b;
  logic              a_on_in1;

  // Tie goes to whoever was not served last; otherwise the sole requester.
  assign sel_win  = (req0 && req1) ? ~last_q : ~req0;
  assign sel_a    = sel_win ? a1 : a0;
  assign sel_b    = sel_win ? b1 : b0;
  assign a_on_in1 = (sel_a[14:0] >= sel_b[14:0]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    win_d    = win_q;
    abort_d  = abort_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = GRANT;
          win_d   = sel_win;
          last_d  = sel_win;
          in1_d   = a_on_in1 ? sel_a : sel_b;
          in2_d   = a_on_in1 ? sel_b : sel_a;
        end
      end
      GRANT: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mul_finish) begin
          state_d  = DROP;
          result_d = mul_out;
          abort_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DROP;
          result_d = '0;
          abort_d  = 1'b1;
        end
      end
      DROP: begin
        if (!mul_finish) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d  = (state_d != IDLE);
    start_d = (state_d == GRANT) || (state_d == WAIT);
    done0_d = (state_d == DONE) && !win_q;
    done1_d = (state_d == DONE) &&  win_q;
    err_d   = (state_d == DONE) && abort_q;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      abort_q  <= 1'b0;
      in1_q    <= '0;
      in2_q    <= '0;
      result_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      win_q    <= win_d;
      abort_q  <= abort_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      result_q <= result_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mul_start = start_q;
  assign mul_in1   = in1_q;
  assign mul_in2   = in2_q;

endmodule
